// File: rtl/dec_pipe_hzd.sv
// Decode-to-execute pipeline with per-stage valid bits, flush, and a RAW
// hazard interlock that tracks writers until their register-file write cycle.
module dec_pipe_hzd #(
    parameter int N_STAGES   = 2,
    parameter int EX_LAT     = 3,
    parameter int PAYLOAD_W  = 128,
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    input  logic [PAYLOAD_W-1:0]  payload_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  regwrite_i,
    input  logic [REG_ADDR_W-1:0] ra_addr_i,
    input  logic [REG_ADDR_W-1:0] rb_addr_i,
    input  logic [REG_ADDR_W-1:0] rc_addr_i,
    input  logic                  ra_use_i,
    input  logic                  rb_use_i,
    input  logic                  rc_use_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  out_valid_o,
    output logic [PAYLOAD_W-1:0]  out_payload_o,
    output logic [REG_ADDR_W-1:0] out_rd_addr_o,
    output logic                  out_regwrite_o,
    output logic [15:0]           stall_cnt_o
);

    localparam int LAST = N_STAGES - 1;

    logic [N_STAGES-1:0]   st_v_q, st_v_d;
    logic [N_STAGES-1:0]   st_rw_q, st_rw_d;
    logic [REG_ADDR_W-1:0] st_rd_q [N_STAGES];
    logic [REG_ADDR_W-1:0] st_rd_d [N_STAGES];
    logic [PAYLOAD_W-1:0]  st_pl_q [N_STAGES];
    logic [PAYLOAD_W-1:0]  st_pl_d [N_STAGES];

    logic [EX_LAT-1:0]     tl_v_q, tl_v_d;
    logic [EX_LAT-1:0]     tl_rw_q, tl_rw_d;
    logic [REG_ADDR_W-1:0] tl_rd_q [EX_LAT];
    logic [REG_ADDR_W-1:0] tl_rd_d [EX_LAT];

    logic [15:0]           stall_cnt_q, stall_cnt_d;
    logic                  hazard_s;
    logic                  accept_s;

    // A used source hits a destination unless it is the hard-wired zero register.
    function automatic logic src_match(input logic                  en,
                                       input logic [REG_ADDR_W-1:0] src,
                                       input logic [REG_ADDR_W-1:0] dst);
        logic zero_excl;
        zero_excl = (ZERO_REG != 0) && (src == {REG_ADDR_W{1'b0}});
        return en && (src == dst) && !zero_excl;
    endfunction

    function automatic logic entry_hit(input logic                  v,
                                       input logic                  rw,
                                       input logic [REG_ADDR_W-1:0] dst,
                                       input logic [REG_ADDR_W-1:0] ra,
                                       input logic                  ra_en,
                                       input logic [REG_ADDR_W-1:0] rb,
                                       input logic                  rb_en,
                                       input logic [REG_ADDR_W-1:0] rc,
                                       input logic                  rc_en);
        return v && rw && (src_match(ra_en, ra, dst) ||
                           src_match(rb_en, rb, dst) ||
                           src_match(rc_en, rc, dst));
    endfunction

    // Scoreboard lookup across decode stages and the execute/writeback tail.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (entry_hit(st_v_q[i], st_rw_q[i], st_rd_q[i], ra_addr_i, ra_use_i,
                          rb_addr_i, rb_use_i, rc_addr_i, rc_use_i)) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
        for (int j = 0; j < EX_LAT; j++) begin
            if (entry_hit(tl_v_q[j], tl_rw_q[j], tl_rd_q[j], ra_addr_i, ra_use_i,
                          rb_addr_i, rb_use_i, rc_addr_i, rc_use_i)) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    assign stall_o  = in_valid_i && hazard_s && !flush_i;
    assign accept_s = in_valid_i && !stall_o && !flush_i;

    // Next-state for the decode stages, tail, and stall counter.
    always_comb begin
        st_v_d     = st_v_q;
        st_rw_d    = st_rw_q;
        st_rd_d    = st_rd_q;
        st_pl_d    = st_pl_q;
        tl_v_d     = tl_v_q;
        tl_rw_d    = tl_rw_q;
        tl_rd_d    = tl_rd_q;

        st_v_d[0]  = accept_s;
        st_rw_d[0] = regwrite_i;
        st_rd_d[0] = rd_addr_i;
        st_pl_d[0] = payload_i;
        for (int i = 1; i < N_STAGES; i++) begin
            st_v_d[i]  = st_v_q[i-1] && !flush_i;
            st_rw_d[i] = st_rw_q[i-1];
            st_rd_d[i] = st_rd_q[i-1];
            st_pl_d[i] = st_pl_q[i-1];
        end

        // Tail takes whatever the last decode stage presented, flush or not.
        tl_v_d[0]  = st_v_q[LAST];
        tl_rw_d[0] = st_rw_q[LAST];
        tl_rd_d[0] = st_rd_q[LAST];
        for (int j = 1; j < EX_LAT; j++) begin
            tl_v_d[j]  = tl_v_q[j-1];
            tl_rw_d[j] = tl_rw_q[j-1];
            tl_rd_d[j] = tl_rd_q[j-1];
        end

        if (stall_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_v_q      <= {N_STAGES{1'b0}};
            st_rw_q     <= {N_STAGES{1'b0}};
            tl_v_q      <= {EX_LAT{1'b0}};
            tl_rw_q     <= {EX_LAT{1'b0}};
            stall_cnt_q <= 16'd0;
            for (int i = 0; i < N_STAGES; i++) begin
                st_rd_q[i] <= {REG_ADDR_W{1'b0}};
                st_pl_q[i] <= {PAYLOAD_W{1'b0}};
            end
            for (int j = 0; j < EX_LAT; j++) begin
                tl_rd_q[j] <= {REG_ADDR_W{1'b0}};
            end
        end else begin
            st_v_q      <= st_v_d;
            st_rw_q     <= st_rw_d;
            st_rd_q     <= st_rd_d;
            st_pl_q     <= st_pl_d;
            tl_v_q      <= tl_v_d;
            tl_rw_q     <= tl_rw_d;
            tl_rd_q     <= tl_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid_o    = st_v_q[LAST];
    assign out_payload_o  = st_pl_q[LAST];
    assign out_rd_addr_o  = st_rd_q[LAST];
    assign out_regwrite_o = st_rw_q[LAST] && st_v_q[LAST];
    assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_dec_pipe_hzd.sv
// Directed bench for dec_pipe_hzd (N_STAGES=2, EX_LAT=3), with a second
// instance using ZERO_REG=1 to check the zero-register exclusion.
module tb_dec_pipe_hzd;

    localparam int PW = 128;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid_i, regwrite_i, flush_i;
    logic [PW-1:0] payload_i;
    logic [AW-1:0] rd_addr_i, ra_addr_i, rb_addr_i, rc_addr_i;
    logic          ra_use_i, rb_use_i, rc_use_i;

    logic          stall_o, out_valid_o, out_regwrite_o;
    logic [PW-1:0] out_payload_o;
    logic [AW-1:0] out_rd_addr_o;
    logic [15:0]   stall_cnt_o;

    logic          z_stall_o, z_out_valid_o, z_out_regwrite_o;
    logic [PW-1:0] z_out_payload_o;
    logic [AW-1:0] z_out_rd_addr_o;
    logic [15:0]   z_stall_cnt_o;

    int            pass_cnt  = 0;
    int            total_cnt = 0;
    logic [15:0]   exp_cnt   = 16'd0;

    always #5 clk = ~clk;

    dec_pipe_hzd #(.N_STAGES(2), .EX_LAT(3), .PAYLOAD_W(PW), .REG_ADDR_W(AW), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .payload_i(payload_i),
        .rd_addr_i(rd_addr_i), .regwrite_i(regwrite_i),
        .ra_addr_i(ra_addr_i), .rb_addr_i(rb_addr_i), .rc_addr_i(rc_addr_i),
        .ra_use_i(ra_use_i), .rb_use_i(rb_use_i), .rc_use_i(rc_use_i),
        .flush_i(flush_i), .stall_o(stall_o), .out_valid_o(out_valid_o),
        .out_payload_o(out_payload_o), .out_rd_addr_o(out_rd_addr_o),
        .out_regwrite_o(out_regwrite_o), .stall_cnt_o(stall_cnt_o)
    );

    dec_pipe_hzd #(.N_STAGES(2), .EX_LAT(3), .PAYLOAD_W(PW), .REG_ADDR_W(AW), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .payload_i(payload_i),
        .rd_addr_i(rd_addr_i), .regwrite_i(regwrite_i),
        .ra_addr_i(ra_addr_i), .rb_addr_i(rb_addr_i), .rc_addr_i(rc_addr_i),
        .ra_use_i(ra_use_i), .rb_use_i(rb_use_i), .rc_use_i(rc_use_i),
        .flush_i(flush_i), .stall_o(z_stall_o), .out_valid_o(z_out_valid_o),
        .out_payload_o(z_out_payload_o), .out_rd_addr_o(z_out_rd_addr_o),
        .out_regwrite_o(z_out_regwrite_o), .stall_cnt_o(z_stall_cnt_o)
    );

    function automatic logic [PW-1:0] mk_pl(input int k);
        return {32'hDEC0_0000 ^ 32'(k), 32'(k), 64'h0123_4567_89AB_CDEF};
    endfunction

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid_i = 1'b0; payload_i = '0; rd_addr_i = '0; regwrite_i = 1'b0;
        ra_addr_i = '0; rb_addr_i = '0; rc_addr_i = '0;
        ra_use_i = 1'b0; rb_use_i = 1'b0; rc_use_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic drv(input logic [PW-1:0] pl, input logic [AW-1:0] rd, input logic rw,
                       input logic [AW-1:0] ra, input logic rau,
                       input logic [AW-1:0] rb, input logic rbu);
        idle();
        in_valid_i = 1'b1; payload_i = pl; rd_addr_i = rd; regwrite_i = rw;
        ra_addr_i = ra; ra_use_i = rau; rb_addr_i = rb; rb_use_i = rbu;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 8; i++) go();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        go(); go();
        smp();
        total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid_o); else pass_cnt++;
        total_cnt++; if (out_regwrite_o !== 1'b0) $display("FAIL reset_regwrite got %b exp 0", out_regwrite_o); else pass_cnt++;
        total_cnt++; if (out_payload_o !== '0) $display("FAIL reset_payload got %h exp 0", out_payload_o); else pass_cnt++;
        total_cnt++; if (out_rd_addr_o !== 5'd0) $display("FAIL reset_rd got %h exp 0", out_rd_addr_o); else pass_cnt++;
        total_cnt++; if (stall_cnt_o !== 16'd0) $display("FAIL reset_cnt got %h exp 0", stall_cnt_o); else pass_cnt++;
        rst = 1'b0;
        go();
    endtask

    task automatic test_stream();
        logic exp_v;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drv(mk_pl(c), 5'(c + 1), 1'b1, 5'(c + 9), 1'b1, 5'(c + 20), 1'b1);
            else idle();
            smp();
            exp_v = (c >= 2) && (c < 6);
            total_cnt++; if (stall_o !== 1'b0) $display("FAIL stream_stall c=%0d got %b exp 0", c, stall_o); else pass_cnt++;
            total_cnt++; if (out_valid_o !== exp_v) $display("FAIL stream_valid c=%0d got %b exp %b", c, out_valid_o, exp_v); else pass_cnt++;
            if (exp_v) begin
                total_cnt++; if (out_payload_o !== mk_pl(c - 2)) $display("FAIL stream_payload c=%0d got %h exp %h", c, out_payload_o, mk_pl(c - 2)); else pass_cnt++;
                total_cnt++; if (out_rd_addr_o !== 5'(c - 1)) $display("FAIL stream_rd c=%0d got %0d exp %0d", c, out_rd_addr_o, c - 1); else pass_cnt++;
                total_cnt++; if (out_regwrite_o !== 1'b1) $display("FAIL stream_regwrite c=%0d got %b exp 1", c, out_regwrite_o); else pass_cnt++;
            end
            go();
        end
        smp();
        total_cnt++; if (stall_cnt_o !== 16'd0) $display("FAIL stream_cnt got %0d exp 0", stall_cnt_o); else pass_cnt++;
    endtask

    task automatic test_hazard();
        int  n;
        logic done;
        drain();
        drv(mk_pl(100), 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        go();
        drv(mk_pl(101), 5'd7, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0);
        n = 0; done = 1'b0;
        for (int g = 0; g < 20 && !done; g++) begin
            smp();
            if (stall_o) begin
                n++;
                go();
            end else begin
                done = 1'b1;
            end
        end
        exp_cnt = exp_cnt + 16'd5;
        total_cnt++; if (n != 5) $display("FAIL hazard_stall_cycles got %0d exp 5", n); else pass_cnt++;
        total_cnt++; if (stall_cnt_o !== exp_cnt) $display("FAIL hazard_cnt got %0d exp %0d", stall_cnt_o, exp_cnt); else pass_cnt++;
        go();
        idle();
        smp();
        total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL hazard_b_early got %b exp 0", out_valid_o); else pass_cnt++;
        go();
        smp();
        total_cnt++; if (out_valid_o !== 1'b1) $display("FAIL hazard_b_valid got %b exp 1", out_valid_o); else pass_cnt++;
        total_cnt++; if (out_payload_o !== mk_pl(101)) $display("FAIL hazard_b_payload got %h exp %h", out_payload_o, mk_pl(101)); else pass_cnt++;
        total_cnt++; if (out_rd_addr_o !== 5'd7) $display("FAIL hazard_b_rd got %0d exp 7", out_rd_addr_o); else pass_cnt++;
        go();
    endtask

    task automatic test_no_stall();
        drain();
        drv(mk_pl(200), 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        go();
        drv(mk_pl(201), 5'd8, 1'b1, 5'd3, 1'b0, 5'd3, 1'b0);
        smp();
        total_cnt++; if (stall_o !== 1'b0) $display("FAIL nostall_unused got %b exp 0", stall_o); else pass_cnt++;
        go();

        drain();
        drv(mk_pl(202), 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        go();
        drv(mk_pl(203), 5'd8, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0);
        smp();
        total_cnt++; if (stall_o !== 1'b0) $display("FAIL nostall_nowrite got %b exp 0", stall_o); else pass_cnt++;
        go();

        drain();
        drv(mk_pl(204), 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        go();
        drv(mk_pl(205), 5'd8, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
        smp();
        total_cnt++; if (z_stall_o !== 1'b0) $display("FAIL nostall_zeroreg got %b exp 0", z_stall_o); else pass_cnt++;
        total_cnt++; if (stall_o !== 1'b1) $display("FAIL stall_r0_nozero got %b exp 1", stall_o); else pass_cnt++;
        go();
        exp_cnt = exp_cnt + 16'd1;

        drain();
        drv(mk_pl(206), 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        go();
        drv(mk_pl(207), 5'd8, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1);
        rc_addr_i = 5'd4; rc_use_i = 1'b1;
        smp();
        total_cnt++; if (stall_o !== 1'b1) $display("FAIL stall_rc got %b exp 1", stall_o); else pass_cnt++;
        go();
        exp_cnt = exp_cnt + 16'd1;
        drain();
        smp();
        total_cnt++; if (stall_cnt_o !== exp_cnt) $display("FAIL nostall_cnt got %0d exp %0d", stall_cnt_o, exp_cnt); else pass_cnt++;
        go();
    endtask

    task automatic test_flush();
        drain();
        drv(mk_pl(300), 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        go();
        drv(mk_pl(301), 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        go();
        drv(mk_pl(302), 5'd11, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
        flush_i = 1'b1;
        smp();
        total_cnt++; if (stall_o !== 1'b0) $display("FAIL flush_stall got %b exp 0", stall_o); else pass_cnt++;
        total_cnt++; if (out_valid_o !== 1'b1) $display("FAIL flush_a_valid got %b exp 1", out_valid_o); else pass_cnt++;
        total_cnt++; if (out_payload_o !== mk_pl(300)) $display("FAIL flush_a_payload got %h exp %h", out_payload_o, mk_pl(300)); else pass_cnt++;
        total_cnt++; if (out_regwrite_o !== 1'b1) $display("FAIL flush_a_regwrite got %b exp 1", out_regwrite_o); else pass_cnt++;
        go();
        drv(mk_pl(303), 5'd9, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            smp();
            total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL flush_killed_valid c=%0d got %b exp 0", c, out_valid_o); else pass_cnt++;
            total_cnt++; if (stall_o !== 1'b1) $display("FAIL flush_tail_kept c=%0d got %b exp 1", c, stall_o); else pass_cnt++;
            go();
        end
        exp_cnt = exp_cnt + 16'd2;
        drain();
        smp();
        total_cnt++; if (stall_cnt_o !== exp_cnt) $display("FAIL flush_cnt got %0d exp %0d", stall_cnt_o, exp_cnt); else pass_cnt++;
        go();
    endtask

    task automatic test_reset_mid();
        drain();
        drv(mk_pl(400), 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        go();
        drv(mk_pl(401), 5'd7, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0);
        smp();
        total_cnt++; if (stall_o !== 1'b1) $display("FAIL rstmid_pre_stall got %b exp 1", stall_o); else pass_cnt++;
        go(); go();
        rst = 1'b1;
        go();
        rst = 1'b0;
        smp();
        total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL rstmid_valid got %b exp 0", out_valid_o); else pass_cnt++;
        total_cnt++; if (stall_o !== 1'b0) $display("FAIL rstmid_stall got %b exp 0", stall_o); else pass_cnt++;
        total_cnt++; if (stall_cnt_o !== 16'd0) $display("FAIL rstmid_cnt got %0d exp 0", stall_cnt_o); else pass_cnt++;
        go();
        idle();
        exp_cnt = 16'd0;
        drain();
    endtask

    task automatic test_saturate();
        int seen;
        rst = 1'b1;
        idle();
        go();
        rst = 1'b0;
        drv(mk_pl(500), 5'd1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);
        seen = 0;
        for (int g = 0; g < 80000 && seen < 65540; g++) begin
            smp();
            if (stall_o) begin
                seen++;
                if (seen == 65535) begin
                    total_cnt++; if (stall_cnt_o !== 16'hFFFE) $display("FAIL sat_pre got %h exp fffe", stall_cnt_o); else pass_cnt++;
                end
            end
            go();
        end
        smp();
        total_cnt++; if (seen != 65540) $display("FAIL sat_seen got %0d exp 65540", seen); else pass_cnt++;
        total_cnt++; if (stall_cnt_o !== 16'hFFFF) $display("FAIL sat_cnt got %h exp ffff", stall_cnt_o); else pass_cnt++;
        go();
        idle();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_stream();
        test_hazard();
        test_no_stall();
        test_flush();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
